// File: rtl/gb_host_arb_pkg.sv
// Shared definitions for the ghostbus host arbiter: requester count, FSM state
// encodings and a one-hot helper.
package gb_host_arb_pkg;

    localparam int NREQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    function automatic logic [NREQ-1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/gb_host_arb_rr_pick.sv
// Combinational two-way round-robin picker with optional owner lock override.
// ptr holds the last winner; on a tie the other requester wins.
module gb_rr_pick
    import gb_host_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic            ptr,
    input  logic            lock_vld,
    input  logic            lock_id,
    output logic [NREQ-1:0] gnt,
    output logic            win
);

    always_comb begin
        win = 1'b0;
        gnt = '0;
        if (lock_vld && req[lock_id]) begin
            win = lock_id;
        end else if (req[0] && req[1]) begin
            win = ~ptr;
        end else begin
            win = req[1];
        end
        if (|req) begin
            gnt = idx_to_onehot(win);
        end
    end

endmodule

// File: rtl/gb_host_arb.sv
// Two-requester ghostbus host arbiter: round-robin grant, one transaction in flight,
// fixed read latency RD. Define GHOSTBUS_ARB_LOCK_EN to honour m_lock.
module gb_host_arb
    import gb_host_arb_pkg::*;
#(
    parameter int AW = 24,
    parameter int DW = 32,
    parameter int RD = 8
) (
    input  logic            gb_clk,
    input  logic            gb_rst,
    input  logic [1:0]      m_req,
    input  logic [1:0]      m_we,
    input  logic [2*AW-1:0] m_addr,
    input  logic [2*DW-1:0] m_wdata,
    input  logic [1:0]      m_lock,
    output logic [1:0]      m_ack,
    output logic [DW-1:0]   m_rdata,
    output logic [1:0]      m_gnt,
    output logic [AW-1:0]   gb_addr,
    output logic [DW-1:0]   gb_wdata,
    output logic            gb_wen,
    output logic            gb_rstb,
    input  logic [DW-1:0]   gb_rdata
);

`ifdef GHOSTBUS_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    // A zero-latency build still needs a legal (unused) counter width.
    localparam int CW = (RD > 0) ? $clog2(RD + 1) : 1;

    logic [AW-1:0] addr_arr  [NREQ];
    logic [DW-1:0] wdata_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_split
            assign addr_arr[gi]  = m_addr[gi*AW +: AW];
            assign wdata_arr[gi] = m_wdata[gi*DW +: DW];
        end
    endgenerate

    arb_state_e      state_q, state_d;
    logic [1:0]      gnt_q, gnt_d;
    logic            ptr_q, ptr_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            lock_vld_q, lock_vld_d;
    logic            lock_id_q, lock_id_d;

    logic [1:0]      pick_gnt;
    logic            pick_win;

    gb_rr_pick u_pick (
        .req      (m_req),
        .ptr      (ptr_q),
        .lock_vld (lock_vld_q && LOCK_EN),
        .lock_id  (lock_id_q),
        .gnt      (pick_gnt),
        .win      (pick_win)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;
        case (state_q)
            ST_IDLE: begin
                if (|m_req) begin
                    gnt_d   = pick_gnt;
                    ptr_d   = pick_win;
                    we_d    = m_we[pick_win];
                    addr_d  = addr_arr[pick_win];
                    wdata_d = wdata_arr[pick_win];
                    // A non-owner served while a lock is held cannot take the lock.
                    if (!(lock_vld_q && (pick_win != lock_id_q))) begin
                        lock_vld_d = m_lock[pick_win];
                        lock_id_d  = pick_win;
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d = ST_DONE;
                end else if (RD == 0) begin
                    rdata_d = gb_rdata;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = CW'(1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CW'(RD)) begin
                    rdata_d = gb_rdata;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge gb_clk) begin
        if (gb_rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            ptr_q      <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            lock_vld_q <= 1'b0;
            lock_id_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
        end
    end

    assign gb_wen   = (state_q == ST_ISSUE) && we_q;
    assign gb_rstb  = (state_q == ST_ISSUE) && !we_q;
    assign m_ack    = (state_q == ST_DONE) ? gnt_q : 2'b00;
    assign m_gnt    = gnt_q;
    assign gb_addr  = addr_q;
    assign gb_wdata = wdata_q;
    assign m_rdata  = rdata_q;

endmodule

// File: tb/tb_gb_host_arb.sv
// Directed bench for gb_host_arb with per-requester scoreboards and a fixed-latency bus model.
module tb_gb_host_arb;

    localparam int AW = 24;
    localparam int DW = 32;
    localparam int RD = 8;

    typedef struct packed {
        logic          we;
        logic          lock;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    logic            gb_clk = 1'b0;
    logic            gb_rst;
    logic [1:0]      m_req, m_we, m_lock;
    logic [2*AW-1:0] m_addr;
    logic [2*DW-1:0] m_wdata;
    logic [1:0]      m_ack, m_gnt;
    logic [DW-1:0]   m_rdata, gb_wdata, gb_rdata;
    logic [AW-1:0]   gb_addr;
    logic            gb_wen, gb_rstb;

    gb_host_arb #(.AW(AW), .DW(DW), .RD(RD)) dut (
        .gb_clk   (gb_clk),
        .gb_rst   (gb_rst),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_lock   (m_lock),
        .m_ack    (m_ack),
        .m_rdata  (m_rdata),
        .m_gnt    (m_gnt),
        .gb_addr  (gb_addr),
        .gb_wdata (gb_wdata),
        .gb_wen   (gb_wen),
        .gb_rstb  (gb_rstb),
        .gb_rdata (gb_rdata)
    );

    always #5 gb_clk = ~gb_clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int strobe_cyc = 0;
    int ack_cyc = 0;
    int ack_cnt = 0;
    int start_cyc [2];
    int bus_k = 0;
    logic [DW-1:0] rd_exp = '0;
    cmd_t cq0[$], cq1[$], eq0[$], eq1[$];
    int glog[$];

    function automatic logic [DW-1:0] bus_data(input logic [AW-1:0] a);
        if (a == 24'h000020) return 32'h12345678;
        return {8'hC3, a} ^ 32'h00A5A5A5;
    endfunction

    always @(posedge gb_clk) cyc <= cyc + 1;

    // Bus returns data only in the exact cycle RD after the read strobe.
    always @(posedge gb_clk) begin
        if (gb_rst) bus_k <= 0;
        else if (gb_rstb) bus_k <= 1;
        else if (bus_k > 0 && bus_k < RD + 4) bus_k <= bus_k + 1;
        else bus_k <= 0;
    end
    assign gb_rdata = (RD == 0) ? (gb_rstb ? bus_data(gb_addr) : 32'hBAD0BAD0)
                                : ((bus_k == RD) ? bus_data(gb_addr) : 32'hBAD0BAD0);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge gb_clk);
            #1;
        end
    endtask

    task automatic push(input int r, input logic we, input logic lock,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_t c;
        c.we = we; c.lock = lock; c.addr = a; c.wdata = d;
        if (r == 0) begin cq0.push_back(c); eq0.push_back(c); end
        else        begin cq1.push_back(c); eq1.push_back(c); end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while ((cq0.size() > 0 || cq1.size() > 0 || m_gnt != 2'b00) && k < budget) begin
            step(1);
            k++;
        end
        chk(tag, (k < budget), 1);
    endtask

    task automatic do_reset();
        gb_rst = 1'b1;
        step(2);
        gb_rst = 1'b0;
        rd_exp = '0;
    endtask

    // Monitor then requester drivers, in one process so ack handling is ordered.
    initial begin
        cmd_t c;
        int   own;
        m_req = '0; m_we = '0; m_lock = '0; m_addr = '0; m_wdata = '0;
        start_cyc[0] = 0; start_cyc[1] = 0;
        forever begin
            @(negedge gb_clk);
            if (gb_rst !== 1'b1) begin
                if (gb_wen || gb_rstb) begin
                    chk("strobe_excl", {63'b0, gb_wen & gb_rstb}, 0);
                    chk("gnt_onehot", {63'b0, $onehot(m_gnt)}, 1);
                    strobe_cyc = cyc;
                    own = m_gnt[1] ? 1 : 0;
                    chk("pending_at_strobe", ((own == 0) ? eq0.size() : eq1.size()) > 0, 1);
                    if ((own == 0 && eq0.size() > 0) || (own == 1 && eq1.size() > 0)) begin
                        c = (own == 0) ? eq0[0] : eq1[0];
                        chk("strobe_kind", {63'b0, gb_wen}, {63'b0, c.we});
                        chk("bus_addr", gb_addr, c.addr);
                        if (gb_wen) chk("bus_wdata", gb_wdata, c.wdata);
                    end
                end
                if (m_ack != 2'b00) begin
                    chk("ack_vs_gnt", m_ack, m_gnt);
                    own = m_ack[1] ? 1 : 0;
                    ack_cyc = cyc;
                    ack_cnt++;
                    glog.push_back(own);
                    if ((own == 0 && eq0.size() > 0) || (own == 1 && eq1.size() > 0)) begin
                        c = (own == 0) ? eq0.pop_front() : eq1.pop_front();
                        chk("ack_latency", ack_cyc - strobe_cyc, c.we ? 1 : RD + 1);
                        if (!c.we) rd_exp = bus_data(c.addr);
                        chk("m_rdata", m_rdata, rd_exp);
                        $display("txn req%0d %s addr=%06h data=%08h at cyc %0d",
                                 own, c.we ? "WR" : "RD", c.addr,
                                 c.we ? c.wdata : m_rdata, cyc);
                    end else begin
                        chk("ack_expected", 0, 1 + own);
                    end
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (m_req[i] && m_ack[i]) begin
                    if (i == 0 && cq0.size() > 0) void'(cq0.pop_front());
                    if (i == 1 && cq1.size() > 0) void'(cq1.pop_front());
                    m_req[i]  = 1'b0;
                    m_lock[i] = 1'b0;
                end
                if (!m_req[i] && ((i == 0) ? cq0.size() : cq1.size()) > 0) begin
                    c = (i == 0) ? cq0[0] : cq1[0];
                    m_req[i]             = 1'b1;
                    m_we[i]              = c.we;
                    m_lock[i]            = c.lock;
                    m_addr[i*AW +: AW]   = c.addr;
                    m_wdata[i*DW +: DW]  = c.wdata;
                    start_cyc[i]         = cyc;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n0;
        int exp_log[4];
        gb_rst = 1'b1;
        step(3);
        chk("rst_ack", m_ack, 0);
        chk("rst_gnt", m_gnt, 0);
        chk("rst_wen", {63'b0, gb_wen}, 0);
        chk("rst_rstb", {63'b0, gb_rstb}, 0);
        chk("rst_addr", gb_addr, 0);
        chk("rst_wdata", gb_wdata, 0);
        chk("rst_rdata", m_rdata, 0);
        gb_rst = 1'b0;
        step(2);

        // Single write from requester 0.
        push(0, 1'b1, 1'b0, 24'h000010, 32'hDEADBEEF);
        wait_done("wr_timeout", 50);
        chk("wr_t1", strobe_cyc - start_cyc[0], 1);
        chk("wr_t2", ack_cyc - start_cyc[0], 2);
        chk("wr_who", glog[glog.size()-1], 0);
        chk("wr_hold_addr", gb_addr, 24'h000010);

        // Single read from requester 1.
        push(1, 1'b0, 1'b0, 24'h000020, 32'h0);
        wait_done("rd_timeout", 50);
        chk("rd_t1", strobe_cyc - start_cyc[1], 1);
        chk("rd_t10", ack_cyc - start_cyc[1], 2 + RD);
        chk("rd_who", glog[glog.size()-1], 1);
        chk("rd_data", m_rdata, 32'h12345678);

        // Both requesting continuously from reset: strict alternation.
        do_reset();
        glog.delete();
        for (int j = 0; j < 4; j++) begin
            push(0, 1'b1, 1'b0, 24'h000100 + 24'(j), 32'hA0000000 + 32'(j));
            push(1, 1'b1, 1'b0, 24'h000200 + 24'(j), 32'hB0000000 + 32'(j));
        end
        wait_done("alt_timeout", 400);
        chk("alt_count", glog.size(), 8);
        for (int j = 0; j < 8 && j < glog.size(); j++) chk("alt_order", glog[j], j % 2);

        // Mixed random reads and writes on both requesters.
        n0 = ack_cnt;
        for (int j = 0; j < 3; j++) begin
            push(0, 1'($urandom_range(0, 1)), 1'b0, 24'($urandom), $urandom);
            push(1, 1'($urandom_range(0, 1)), 1'b0, 24'($urandom), $urandom);
        end
        wait_done("mix_timeout", 400);
        chk("mix_count", ack_cnt - n0, 6);

        // Reset in the middle of a read wait: no ack, clean restart.
        n0 = ack_cnt;
        push(1, 1'b0, 1'b0, 24'h000030, 32'h0);
        begin
            int k = 0;
            int t0 = cyc;
            while (strobe_cyc < t0 && k < 20) begin step(1); k++; end
            chk("rst_wait_strobe", (k < 20), 1);
        end
        step(3);
        cq1.delete();
        eq1.delete();
        m_req[1] = 1'b0;
        gb_rst = 1'b1;
        step(1);
        gb_rst = 1'b0;
        rd_exp = '0;
        chk("midrst_gnt", m_gnt, 0);
        chk("midrst_rstb", {63'b0, gb_rstb}, 0);
        chk("midrst_ack", m_ack, 0);
        step(RD + 4);
        chk("midrst_no_ack", ack_cnt - n0, 0);
        push(0, 1'b1, 1'b0, 24'h000040, 32'hCAFEF00D);
        wait_done("postrst_timeout", 50);
        chk("postrst_count", ack_cnt - n0, 1);
        chk("postrst_wdata", gb_wdata, 32'hCAFEF00D);

        // Lock request from requester 0 while requester 1 waits.
        do_reset();
        glog.delete();
        push(0, 1'b1, 1'b1, 24'h000050, 32'h11111111);
        push(0, 1'b1, 1'b1, 24'h000051, 32'h22222222);
        push(0, 1'b1, 1'b0, 24'h000052, 32'h33333333);
        push(1, 1'b1, 1'b0, 24'h000060, 32'h44444444);
        wait_done("lock_timeout", 200);
`ifdef GHOSTBUS_ARB_LOCK_EN
        exp_log = '{0, 0, 0, 1};
`else
        exp_log = '{0, 1, 0, 0};
`endif
        chk("lock_count", glog.size(), 4);
        for (int j = 0; j < 4 && j < glog.size(); j++) chk("lock_order", glog[j], exp_log[j]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
